// File: rtl/program_counter.sv
// Program-counter register: samples the next-PC value on every rising clock edge,
// with an optional word-alignment mask and an asynchronous active-low reset.
module program_counter #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               FORCE_ALIGN = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_output
);

  // Clears the two LSBs when alignment is forced; otherwise passes every bit.
  localparam logic [WIDTH-1:0] ALIGN_MASK = FORCE_ALIGN ? ~WIDTH'(3) : '1;

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  always_comb begin
    pc_d = PC & ALIGN_MASK;
  end

  // Loads on every edge, with no enable; reset wins over the clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_output = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed testbench for program_counter.
// Rising clock edges fall at 20, 40, 60, ... ns.
`timescale 1ns/1ps
module tb_program_counter;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] pc_out;
  logic [31:0] pc_al;

  int errors = 0;
  int checks = 0;

  program_counter #(.WIDTH(32), .RESET_VALUE(32'h0000_0000), .FORCE_ALIGN(1'b0)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .PC       (pc),
    .PC_output(pc_out)
  );

  program_counter #(.WIDTH(32), .RESET_VALUE(32'h0000_0000), .FORCE_ALIGN(1'b1)) dut_al (
    .clk      (clk),
    .reset_n  (reset_n),
    .PC       (pc),
    .PC_output(pc_al)
  );

  initial begin
    clk = 1'b0;
    #10;
    forever #10 clk = ~clk;
  end

  task automatic wait_until(input int t);
    if ($time < t) #(t - $time);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    pc      = 32'd0;
    wait_until(2);
    reset_n = 1'b0;
    wait_until(5);
    checks++;
    if (pc_out !== 32'd0) begin
      errors++; $display("FAIL reset_assert: got %h want %h", pc_out, 32'd0);
    end
    wait_until(8);
    reset_n = 1'b1;
    pc      = 32'd111101111;
    wait_until(15);
    checks++;
    if (pc_out !== 32'd0) begin
      errors++; $display("FAIL reset_release_hold: got %h want %h", pc_out, 32'd0);
    end
  endtask

  task automatic test_load();
    wait_until(21);
    checks++;
    if (pc_out !== 32'd111101111) begin
      errors++; $display("FAIL load_first: got %0d want %0d", pc_out, 32'd111101111);
    end
    checks++;
    if (pc_al !== 32'd111101108) begin
      errors++; $display("FAIL load_first_aligned: got %0d want %0d", pc_al, 32'd111101108);
    end
  endtask

  task automatic test_async_pulse();
    wait_until(25);
    reset_n = 1'b0;
    wait_until(26);
    checks++;
    if (pc_out !== 32'd0) begin
      errors++; $display("FAIL async_reset_immediate: got %0d want 0", pc_out);
    end
    wait_until(29);
    checks++;
    if (pc_out !== 32'd0) begin
      errors++; $display("FAIL async_reset_held: got %0d want 0", pc_out);
    end
    wait_until(30);
    reset_n = 1'b1;
    pc      = 32'd35533222;
    wait_until(39);
    checks++;
    if (pc_out !== 32'd0) begin
      errors++; $display("FAIL post_release_before_edge: got %0d want 0", pc_out);
    end
    wait_until(41);
    checks++;
    if (pc_out !== 32'd35533222) begin
      errors++; $display("FAIL post_release_edge: got %0d want %0d", pc_out, 32'd35533222);
    end
  endtask

  task automatic test_mid_cycle_change();
    wait_until(55);
    pc = 32'd20242025;
    wait_until(56);
    checks++;
    if (pc_out !== 32'd35533222) begin
      errors++; $display("FAIL midcycle_no_passthrough: got %0d want %0d", pc_out, 32'd35533222);
    end
    wait_until(59);
    checks++;
    if (pc_out !== 32'd35533222) begin
      errors++; $display("FAIL midcycle_hold: got %0d want %0d", pc_out, 32'd35533222);
    end
    wait_until(61);
    checks++;
    if (pc_out !== 32'd20242025) begin
      errors++; $display("FAIL midcycle_edge_load: got %0d want %0d", pc_out, 32'd20242025);
    end
  endtask

  task automatic test_reset_across_edges();
    logic [31:0] vals [3] = '{32'hDEAD_BEEF, 32'h1234_5677, 32'hFFFF_FFFF};
    wait_until(65);
    reset_n = 1'b0;
    wait_until(66);
    checks++;
    if (pc_out !== 32'd0) begin
      errors++; $display("FAIL reset_mid_operation: got %h want 0", pc_out);
    end
    for (int i = 0; i < 3; i++) begin
      wait_until(70 + 20 * i);
      pc = vals[i];
      wait_until(81 + 20 * i);
      checks++;
      if (pc_out !== 32'd0) begin
        errors++; $display("FAIL reset_over_edge_%0d: got %h want 0", i, pc_out);
      end
    end
    wait_until(125);
    reset_n = 1'b1;
    pc      = 32'hA5A5_0003;
    wait_until(130);
    checks++;
    if (pc_out !== 32'd0) begin
      errors++; $display("FAIL reset2_release_hold: got %h want 0", pc_out);
    end
    wait_until(141);
    checks++;
    if (pc_out !== 32'hA5A5_0003) begin
      errors++; $display("FAIL reset2_first_load: got %h want %h", pc_out, 32'hA5A5_0003);
    end
  endtask

  task automatic test_boundary();
    wait_until(145);
    pc = 32'hFFFF_FFFF;
    wait_until(161);
    checks++;
    if (pc_out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL max_value: got %h want FFFFFFFF", pc_out);
    end
    checks++;
    if (pc_al !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL max_value_aligned: got %h want FFFFFFFC", pc_al);
    end
    wait_until(165);
    pc = 32'h0000_0000;
    wait_until(181);
    checks++;
    if (pc_out !== 32'h0000_0000) begin
      errors++; $display("FAIL zero_value: got %h want 00000000", pc_out);
    end
    wait_until(185);
    pc = 32'h0000_0007;
    wait_until(201);
    checks++;
    if (pc_out !== 32'h0000_0007) begin
      errors++; $display("FAIL unaligned_passthrough: got %h want 00000007", pc_out);
    end
    checks++;
    if (pc_al !== 32'h0000_0004) begin
      errors++; $display("FAIL force_align: got %h want 00000004", pc_al);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFFE};
    logic [31:0] al  [4] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFC};
    for (int i = 0; i < 4; i++) begin
      wait_until(205 + 20 * i);
      pc = seq[i];
      wait_until(221 + 20 * i);
      checks++;
      if (pc_out !== seq[i]) begin
        errors++; $display("FAIL back_to_back_%0d: got %h want %h", i, pc_out, seq[i]);
      end
      checks++;
      if (pc_al !== al[i]) begin
        errors++; $display("FAIL back_to_back_aligned_%0d: got %h want %h", i, pc_al, al[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_async_pulse();
    test_mid_cycle_change();
    test_reset_across_edges();
    test_boundary();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
